lmk_spi_arbiter: RTL
====================

# lmk_spi_arbiter

Shares the single 3-wire SPI port of the LMK04610 clock generator between two requesters. Requester 0 is the power-up configuration sequencer and requester 1 is the CPU/host register-access path. The block performs round-robin arbitration, then serialises one 24-bit frame per grant, with optional 8-bit readback over the bidirectional SDIO line. It sits between the requesters and the board pins; the top level builds the SDIO tristate from `O_Lmk_Sdio` and `O_Lmk_Sdio_Oe`.

## Interface
Parameters:
- `CLK_DIV`, default 2: I_Clk cycles per SCL half-period (D). Legal range 1..255.
- `CS_GAP`, default 4: I_Clk cycles with CSn high between frames. Legal range 1..255.

Ports (reset `I_Rst_n`, asynchronous, active-low; clock `I_Clk`):
- `I_Clk` in 1: system clock.
- `I_Rst_n` in 1: asynchronous active-low reset.
- `I_Req0` in 1: request from requester 0. Level signal, held until `O_Ack0`.
- `I_Frame0` in 24: frame for requester 0, laid out as {R/W, addr[14:0], data[7:0]}. Stable while `I_Req0` is high.
- `O_Ack0` out 1: 1-cycle pulse; frame 0 accepted.
- `O_Done0` out 1: 1-cycle pulse; frame 0 complete on the wire.
- `I_Req1`, `I_Frame1`, `O_Ack1`, `O_Done1`: same definitions for requester 1.
- `O_RdData` out 8: readback byte. Updated only at the completion of a read frame and valid from the `O_DoneX` pulse onward.
- `O_Busy` out 1: high from the ack cycle through the last GAP cycle.
- `O_Lmk_Scsn` out 1: SPI chip select, active low.
- `O_Lmk_Scl` out 1: SPI clock.
- `O_Lmk_Sdio` out 1: SDIO output data.
- `O_Lmk_Sdio_Oe` out 1: SDIO output enable, 1 = FPGA drives.
- `I_Lmk_Sdio` in 1: SDIO input sampled from the pad.

## Operation
- **States:** IDLE, LO, HI, HOLD, GAP.
- **IDLE:**
  - Samples `I_Req0` and `I_Req1`. Requests are sampled only in IDLE.
  - Grant: if only one request is high, grant it. If both are high, grant the requester not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
  - On grant: latch the frame, set bit index to 23, pulse `O_AckX` in the next cycle, go to LO.
- **LO:** D cycles. SCL=0, CSn=0, SDIO drives frame[index]. Then go to HI.
- **HI:** D cycles. SCL=1. Then:
  - If index is 0, go to HOLD.
  - Otherwise decrement index and go to LO.
- **Read frames (frame[23]=1):**
  - For index 7..0, `O_Lmk_Sdio_Oe`=0 and `O_Lmk_Sdio`=0 for the whole bit (LO and HI phases).
  - `I_Lmk_Sdio` is sampled on the last HI cycle of each of those bits and shifted MSB-first into the readback register.
  - `O_Lmk_Sdio_Oe` returns to 1 on entry to HOLD.
- **Write frames:** `O_Lmk_Sdio_Oe`=1 throughout. `O_RdData` is unchanged.
- **HOLD:** D cycles. SCL=0, CSn=0, SDIO=0. Then go to GAP.
- **GAP:** CS_GAP cycles. CSn=1, SCL=0, SDIO=0.
  - `O_DoneX` pulses in the first GAP cycle.
  - `O_RdData` is loaded in the same cycle, for read frames only.
  - Then go to IDLE.
- **Requester handshake:** a request that is still high when the arbiter returns to IDLE counts as a new request. Requesters must drop `I_ReqX` in the cycle they see `O_AckX`.
- **Non-granted request:** a request arriving or held during a frame waits. It is never dropped and never acked early.
- **Asynchronous reset, at any point including mid-frame:**
  - State goes to IDLE and the pointer to 1.
  - Outputs take these values: CSn=1, SCL=0, SDIO=0, Oe=1, Ack0/1=0, Done0/1=0, Busy=0, RdData=0.
  - An aborted frame produces no Done.
  - The first frame after reset release is sent in full.

## Timing
- **Grant to first clock edge:** IDLE grant in cycle N. In cycle N+1: Ack=1, CSn=0, SCL=0, SDIO=frame[23]. The first SCL rising edge occurs at N+1+D.
- **SCL period:** 2D cycles. Data changes only on entry to LO, i.e. coincident with the SCL falling edge. SDIO is stable for D cycles before and D cycles after each rising edge.
- **CSn low duration:** exactly 48D+D cycles (24 bits plus HOLD). Done pulses in the first cycle after CSn rises.
- **Frame-to-frame repeat** with a continuous request: 1 (IDLE) + 49D + CS_GAP cycles.
- **Counters:** 8-bit phase counter and 5-bit bit index. The bit index never wraps below 0.

## Test plan
- **Single write.** D=2, GAP=4, Req0 with 0x00AD30.
  - Ack0 is one cycle after the request.
  - CSn is low for 98 cycles and there are 24 SCL rising edges.
  - Bits captured on the rising edges equal 0x00AD30 MSB-first, with Oe=1 throughout.
  - Done0 pulses once; Done1 never pulses.
- **Read.** Req1 with 0x800C00; the slave model drives 0x51 on bits 7..0.
  - Oe=0 only during those 8 bits.
  - RdData=0x51 at Done1.
  - A following write to 0x000C00 leaves RdData at 0x51.
- **Arbitration.** Req0 and Req1 held high from reset.
  - Grant order is 0,1,0,1.
  - Each Ack is preceded by ≥ CS_GAP cycles with CSn high.
  - Req1 alone is granted immediately from IDLE.
- **Reset mid-frame.** Assert I_Rst_n low at bit index 10 of a write.
  - CSn=1, SCL=0 and Busy=0 immediately.
  - No Done is produced.
  - After release, a new Req0 frame completes correctly.
- **Boundary case.** D=1, GAP=1.
  - SCL toggles every cycle.
  - CSn is low for 49 cycles.
  - Back-to-back frames repeat every 51 cycles.

Source files
------------

// File: rtl/lmk_spi_arbiter.sv
// lmk_spi_arbiter
// Round-robin arbiter sharing the LMK04610 3-wire SPI port between two
// requesters (0 = power-up sequencer, 1 = host register path). Each grant
// sends one 24-bit frame {R/W, addr[14:0], data[7:0]} MSB-first. On read
// frames the FPGA releases SDIO for the 8 data bits and shifts the returned
// byte into O_RdData.
//
// Ports:
//   I_Clk, I_Rst_n          system clock, async active-low reset
//   I_Req0/1, I_Frame0/1    level requests (held until ack) and frames
//   O_Ack0/1                1-cycle pulse, frame accepted
//   O_Done0/1               1-cycle pulse, frame finished on the wire
//   O_RdData                readback byte, updated only at end of a read
//   O_Busy                  high from ack cycle through last GAP cycle
//   O_Lmk_Scsn/Scl          SPI chip select (active low) and clock
//   O_Lmk_Sdio/_Oe          SDIO output data and enable (1 = FPGA drives)
//   I_Lmk_Sdio              SDIO input from the pad
module lmk_spi_arbiter #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        I_Clk,
  input  logic        I_Rst_n,
  input  logic        I_Req0,
  input  logic [23:0] I_Frame0,
  output logic        O_Ack0,
  output logic        O_Done0,
  input  logic        I_Req1,
  input  logic [23:0] I_Frame1,
  output logic        O_Ack1,
  output logic        O_Done1,
  output logic [7:0]  O_RdData,
  output logic        O_Busy,
  output logic        O_Lmk_Scsn,
  output logic        O_Lmk_Scl,
  output logic        O_Lmk_Sdio,
  output logic        O_Lmk_Sdio_Oe,
  input  logic        I_Lmk_Sdio
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [4:0]  idx;
  logic [23:0] frame;
  logic [7:0]  shift;
  logic        last_grant;
  logic        cur;
  logic        grant_sel;
  logic        is_read;
  logic        in_bit;
  logic        rd_bit;

  // Both requesting: take the one not served last; otherwise whoever asks.
  always_comb begin
    grant_sel = I_Req1;
    if (I_Req0 && I_Req1) grant_sel = ~last_grant;
  end

  assign is_read = frame[23];
  assign in_bit  = (state == S_LO) || (state == S_HI);
  assign rd_bit  = in_bit && is_read && (idx < 5'd8);

  // Pin outputs decode the registered state, so they change only on clock
  // edges and fall straight to their idle values under async reset.
  assign O_Lmk_Scsn    = ~(in_bit || (state == S_HOLD));
  assign O_Lmk_Scl     = (state == S_HI);
  assign O_Lmk_Sdio_Oe = ~rd_bit;
  assign O_Lmk_Sdio    = in_bit && !rd_bit && frame[idx];
  assign O_Busy        = (state != S_IDLE);

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame      <= '0;
      shift      <= '0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      O_Ack0     <= 1'b0;
      O_Ack1     <= 1'b0;
      O_Done0    <= 1'b0;
      O_Done1    <= 1'b0;
      O_RdData   <= '0;
    end else begin
      O_Ack0  <= 1'b0;
      O_Ack1  <= 1'b0;
      O_Done0 <= 1'b0;
      O_Done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (I_Req0 || I_Req1) begin
            frame      <= grant_sel ? I_Frame1 : I_Frame0;
            cur        <= grant_sel;
            last_grant <= grant_sel;
            idx        <= 5'd23;
            O_Ack0     <= ~grant_sel;
            O_Ack1     <= grant_sel;
            state      <= S_LO;
          end
        end
        S_LO: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= S_HI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HI: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            // Readback is sampled on the last HI cycle, just before SCL falls.
            if (is_read && (idx < 5'd8)) shift <= {shift[6:0], I_Lmk_Sdio};
            if (idx == 5'd0) begin
              state <= S_HOLD;
            end else begin
              idx   <= idx - 5'd1;
              state <= S_LO;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            state   <= S_GAP;
            O_Done0 <= ~cur;
            O_Done1 <= cur;
            if (is_read) O_RdData <= shift;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
